// File: rtl/bridge_pkg.sv
// Shared definitions for the PCIe-to-AXI-Lite bridge read and write controllers.
package bridge_pkg;

  localparam logic [4:0] StIdle     = 5'b00001;
  localparam logic [4:0] StReadReq  = 5'b00010;
  localparam logic [4:0] StReadData = 5'b00100;
  localparam logic [4:0] StCpl      = 5'b01000;
  localparam logic [4:0] StFlush    = 5'b10000;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  // {base[63:size], pcie_address[size-1:2], 2'b00}; bits above the address width drop later.
  function automatic logic [63:0] bar_xlate(input logic [63:0] base, input int unsigned size,
                                            input logic [31:0] pcie_address);
    logic [63:0] mask;
    mask = (64'd1 << size) - 64'd1;
    return (base & ~mask) | ({32'd0, pcie_address} & mask & ~64'h3);
  endfunction

endpackage

// File: rtl/axi_bar_xlate.sv
// BAR-hit to AXI address translation plus physical offset add; shared by read and write paths.
module axi_bar_xlate
  import bridge_pkg::*;
#(
  parameter int unsigned M_AXI_ADDR_WIDTH = 48,
  parameter logic [63:0] BAR0AXI          = 64'h0,
  parameter logic [63:0] BAR1AXI          = 64'h0,
  parameter logic [63:0] BAR2AXI          = 64'h0,
  parameter logic [63:0] BAR3AXI          = 64'h0,
  parameter logic [63:0] BAR4AXI          = 64'h0,
  parameter logic [63:0] BAR5AXI          = 64'h0,
  parameter int unsigned BAR0SIZE         = 12,
  parameter int unsigned BAR1SIZE         = 12,
  parameter int unsigned BAR2SIZE         = 12,
  parameter int unsigned BAR3SIZE         = 12,
  parameter int unsigned BAR4SIZE         = 12,
  parameter int unsigned BAR5SIZE         = 12
) (
  input  logic [2:0]                  bar_hit,
  input  logic [31:0]                 pcie_address,
  input  logic [63:0]                 phy_addr,
  output logic [M_AXI_ADDR_WIDTH-1:0] axi_addr
);

  logic [63:0] base_sel;
  logic [63:0] sum;
  logic        unused_sum;

  always_comb begin
    base_sel = 64'd0;
    case (bar_hit)
      3'd0:    base_sel = bar_xlate(BAR0AXI, BAR0SIZE, pcie_address);
      3'd1:    base_sel = bar_xlate(BAR1AXI, BAR1SIZE, pcie_address);
      3'd2:    base_sel = bar_xlate(BAR2AXI, BAR2SIZE, pcie_address);
      3'd3:    base_sel = bar_xlate(BAR3AXI, BAR3SIZE, pcie_address);
      3'd4:    base_sel = bar_xlate(BAR4AXI, BAR4SIZE, pcie_address);
      3'd5:    base_sel = bar_xlate(BAR5AXI, BAR5SIZE, pcie_address);
      default: base_sel = 64'd0;
    endcase
  end

  assign sum        = base_sel + phy_addr;
  assign axi_addr   = sum[M_AXI_ADDR_WIDTH-1:0];
  assign unused_sum = ^sum;

endmodule

// File: rtl/axi_read_controller.sv
// AXI4-Lite single-beat read master with response watchdog, feeding the completion generator.
module axi_read_controller
  import bridge_pkg::*;
#(
  parameter int          TCQ               = 1,
  parameter int unsigned M_AXI_TDATA_WIDTH = 64,
  parameter int unsigned M_AXI_ADDR_WIDTH  = 48,
  parameter logic [63:0] BAR0AXI           = 64'h0,
  parameter logic [63:0] BAR1AXI           = 64'h0,
  parameter logic [63:0] BAR2AXI           = 64'h0,
  parameter logic [63:0] BAR3AXI           = 64'h0,
  parameter logic [63:0] BAR4AXI           = 64'h0,
  parameter logic [63:0] BAR5AXI           = 64'h0,
  parameter int unsigned BAR0SIZE          = 12,
  parameter int unsigned BAR1SIZE          = 12,
  parameter int unsigned BAR2SIZE          = 12,
  parameter int unsigned BAR3SIZE          = 12,
  parameter int unsigned BAR4SIZE          = 12,
  parameter int unsigned BAR5SIZE          = 12,
  parameter int unsigned TIMEOUT_CYCLES    = 1024
) (
  input  logic                         m_axi_aclk,
  input  logic                         m_axi_areset,
  output logic [M_AXI_ADDR_WIDTH-1:0]  m_axi_araddr,
  output logic [2:0]                   m_axi_arprot,
  output logic                         m_axi_arvalid,
  input  logic                         m_axi_arready,
  input  logic [M_AXI_TDATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                   m_axi_rresp,
  input  logic                         m_axi_rvalid,
  output logic                         m_axi_rready,
  input  logic                         mem_req_valid,
  output logic                         mem_req_ready,
  input  logic [2:0]                   mem_req_bar_hit,
  input  logic [31:0]                  mem_req_pcie_address,
  input  logic                         mem_req_write_readn,
  input  logic [63:0]                  phy_addr,
  output logic                         cpl_valid,
  input  logic                         cpl_ready,
  output logic [M_AXI_TDATA_WIDTH-1:0] cpl_data,
  output logic [1:0]                   cpl_resp,
  output logic [15:0]                  timeout_count
);

  localparam int unsigned WdogW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WdogW-1:0] WdogMax = WdogW'(TIMEOUT_CYCLES - 1);

  // TCQ only matters to legacy simulation models; registers here carry no delay.
  if (TIMEOUT_CYCLES < 2 || TCQ < 0) begin : gen_param_err
    $error("axi_read_controller: TIMEOUT_CYCLES must be >= 2 and TCQ >= 0");
  end

  logic [4:0]                   state_q, state_d;
  logic [M_AXI_ADDR_WIDTH-1:0]  araddr_q, araddr_d, xlate_addr;
  logic                         req_ready_q, req_ready_d;
  logic                         arvalid_q, arvalid_d;
  logic                         rready_q, rready_d;
  logic                         cpl_valid_q, cpl_valid_d;
  logic                         flush_q, flush_d;
  logic [M_AXI_TDATA_WIDTH-1:0] cpl_data_q, cpl_data_d;
  logic [1:0]                   cpl_resp_q, cpl_resp_d;
  logic [WdogW-1:0]             wdog_q, wdog_d;
  logic [15:0]                  tcount_q, tcount_d;
  logic                         expired, tcount_inc;

  // Address is latched at acceptance so it cannot move while arvalid is high.
  axi_bar_xlate #(
    .M_AXI_ADDR_WIDTH(M_AXI_ADDR_WIDTH),
    .BAR0AXI(BAR0AXI), .BAR1AXI(BAR1AXI), .BAR2AXI(BAR2AXI),
    .BAR3AXI(BAR3AXI), .BAR4AXI(BAR4AXI), .BAR5AXI(BAR5AXI),
    .BAR0SIZE(BAR0SIZE), .BAR1SIZE(BAR1SIZE), .BAR2SIZE(BAR2SIZE),
    .BAR3SIZE(BAR3SIZE), .BAR4SIZE(BAR4SIZE), .BAR5SIZE(BAR5SIZE)
  ) u_xlate (
    .bar_hit     (mem_req_bar_hit),
    .pcie_address(mem_req_pcie_address),
    .phy_addr    (phy_addr),
    .axi_addr    (xlate_addr)
  );

  assign expired = (wdog_q == WdogMax);

  always_comb begin
    state_d     = state_q;
    araddr_d    = araddr_q;
    req_ready_d = req_ready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    cpl_valid_d = cpl_valid_q;
    cpl_data_d  = cpl_data_q;
    cpl_resp_d  = cpl_resp_q;
    flush_d     = flush_q;
    wdog_d      = '0;
    tcount_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready_d = 1'b1;
        if (mem_req_valid && req_ready_q && !mem_req_write_readn) begin
          state_d     = StReadReq;
          araddr_d    = xlate_addr;
          req_ready_d = 1'b0;
          arvalid_d   = 1'b1;
        end
      end
      StReadReq: begin
        if (m_axi_arready) begin
          state_d   = StReadData;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (expired) begin
          // arvalid may not be withdrawn; log the expiry and restart the wait.
          tcount_inc = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StReadData: begin
        if (m_axi_rvalid) begin
          state_d     = StCpl;
          rready_d    = 1'b0;
          cpl_valid_d = 1'b1;
          cpl_data_d  = m_axi_rdata;
          cpl_resp_d  = m_axi_rresp;
        end else if (expired) begin
          state_d     = StCpl;
          rready_d    = 1'b0;
          cpl_valid_d = 1'b1;
          cpl_data_d  = '1;
          cpl_resp_d  = RespSlverr;
          flush_d     = 1'b1;
          tcount_inc  = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      StCpl: begin
        if (cpl_ready) begin
          cpl_valid_d = 1'b0;
          if (flush_q) begin
            state_d  = StFlush;
            rready_d = 1'b1;
            flush_d  = 1'b0;
          end else begin
            state_d     = StIdle;
            req_ready_d = 1'b1;
          end
        end
      end
      StFlush: begin
        // Swallow the late beat of a timed-out read so it cannot complete the next one.
        if (m_axi_rvalid || expired) begin
          state_d     = StIdle;
          rready_d    = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        req_ready_d = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        cpl_valid_d = 1'b0;
        flush_d     = 1'b0;
      end
    endcase
    tcount_d = (tcount_inc && tcount_q != 16'hFFFF) ? tcount_q + 16'd1 : tcount_q;
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q     <= StIdle;
      araddr_q    <= '0;
      req_ready_q <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      cpl_valid_q <= 1'b0;
      cpl_data_q  <= '0;
      cpl_resp_q  <= RespOkay;
      flush_q     <= 1'b0;
      wdog_q      <= '0;
      tcount_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      araddr_q    <= araddr_d;
      req_ready_q <= req_ready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_data_q  <= cpl_data_d;
      cpl_resp_q  <= cpl_resp_d;
      flush_q     <= flush_d;
      wdog_q      <= wdog_d;
      tcount_q    <= tcount_d;
    end
  end

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;
  assign mem_req_ready = req_ready_q;
  assign cpl_valid     = cpl_valid_q;
  assign cpl_data      = cpl_data_q;
  assign cpl_resp      = cpl_resp_q;
  assign timeout_count = tcount_q;

endmodule
